prog_loader: RTL and testbench

//  Upstream front-end for the X9 single-cycle core. Accepts a stream of 9-bit machine

---
 rtl/prog_loader.sv | 130 +++++++++++++
 tb/tb_prog_loader.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/prog_loader.sv
// Program loader for the X9 core: streams words into instruction memory, then runs the core to completion.
// Optional run-cycle counter enabled by defining PROG_LOADER_CYCLE_COUNT_EN.
module prog_loader #(
    parameter int D  = 12,
    parameter int W  = 9,
    parameter int CW = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] in_data,
    input  logic         in_valid,
    input  logic         in_last,
    output logic         in_ready,
    output logic         im_wr_en,
    output logic [D-1:0] im_wr_addr,
    output logic [W-1:0] im_wr_data,
    output logic         core_rst,
    input  logic         core_done,
    output logic         busy,
    output logic         finished,
    output logic         err_ovf,
    output logic [D:0]   prog_len,
    output logic [CW-1:0] run_cycles
);

    typedef enum logic [2:0] {
        S_LOAD  = 3'd0,
        S_START = 3'd1,
        S_RUN   = 3'd2,
        S_DONE  = 3'd3,
        S_ERR   = 3'd4
    } state_e;

    state_e       state_q;
    logic [D-1:0] wr_ptr_q;
    logic [D:0]   prog_len_q;
    logic         im_wr_en_q;
    logic [D-1:0] im_wr_addr_q;
    logic [W-1:0] im_wr_data_q;
    logic         finished_q;
    logic         err_ovf_q;
    logic         xfer;
    logic         to_start;

    assign in_ready = (state_q == S_LOAD) || (state_q == S_DONE);
    assign xfer     = in_valid && in_ready;
    assign to_start = xfer && in_last;

    // Core is held in reset everywhere except RUN, so the PC always restarts at 0.
    assign core_rst   = (state_q != S_RUN);
    assign busy       = (state_q == S_LOAD) || (state_q == S_START) || (state_q == S_RUN);
    assign im_wr_en   = im_wr_en_q;
    assign im_wr_addr = im_wr_addr_q;
    assign im_wr_data = im_wr_data_q;
    assign finished   = finished_q;
    assign err_ovf    = err_ovf_q;
    assign prog_len   = prog_len_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= S_LOAD;
            wr_ptr_q     <= '0;
            prog_len_q   <= '0;
            im_wr_en_q   <= 1'b0;
            im_wr_addr_q <= '0;
            im_wr_data_q <= '0;
            finished_q   <= 1'b0;
            err_ovf_q    <= 1'b0;
        end else begin
            im_wr_en_q <= 1'b0;
            case (state_q)
                S_LOAD: begin
                    if (xfer) begin
                        im_wr_en_q   <= 1'b1;
                        im_wr_addr_q <= wr_ptr_q;
                        im_wr_data_q <= in_data;
                        wr_ptr_q     <= wr_ptr_q + 1'b1;
                        prog_len_q   <= prog_len_q + 1'b1;
                        if (in_last) begin
                            state_q <= S_START;
                        end else if (wr_ptr_q == '1) begin
                            state_q   <= S_ERR;
                            err_ovf_q <= 1'b1;
                        end
                    end
                end
                S_START: state_q <= S_RUN;
                S_RUN: begin
                    if (core_done) begin
                        state_q    <= S_DONE;
                        finished_q <= 1'b1;
                    end
                end
                S_DONE: begin
                    // First word of a new program restarts addressing at 0.
                    if (xfer) begin
                        im_wr_en_q   <= 1'b1;
                        im_wr_addr_q <= '0;
                        im_wr_data_q <= in_data;
                        wr_ptr_q     <= {{(D-1){1'b0}}, 1'b1};
                        prog_len_q   <= {{D{1'b0}}, 1'b1};
                        finished_q   <= 1'b0;
                        state_q      <= in_last ? S_START : S_LOAD;
                    end
                end
                S_ERR:   state_q <= S_ERR;
                default: state_q <= S_LOAD;
            endcase
        end
    end

`ifdef PROG_LOADER_CYCLE_COUNT_EN
    logic [CW-1:0] run_cycles_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            run_cycles_q <= '0;
        end else if (to_start) begin
            run_cycles_q <= '0;
        end else if (state_q == S_RUN && run_cycles_q != '1) begin
            run_cycles_q <= run_cycles_q + 1'b1;
        end
    end

    assign run_cycles = run_cycles_q;
`else
    assign run_cycles = '0;
`endif

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader (D=4): load, run, gapped load, reset mid-run, overflow, reload.
module tb_prog_loader;

    localparam int D  = 4;
    localparam int W  = 9;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic [W-1:0]  in_data;
    logic          in_valid;
    logic          in_last;
    logic          in_ready;
    logic          im_wr_en;
    logic [D-1:0]  im_wr_addr;
    logic [W-1:0]  im_wr_data;
    logic          core_rst;
    logic          core_done;
    logic          busy;
    logic          finished;
    logic          err_ovf;
    logic [D:0]    prog_len;
    logic [CW-1:0] run_cycles;

    int vectors    = 0;
    int miscompares = 0;

`ifdef PROG_LOADER_CYCLE_COUNT_EN
    localparam int RUN11 = 11;
    localparam int RUN1  = 1;
`else
    localparam int RUN11 = 0;
    localparam int RUN1  = 0;
`endif

    prog_loader #(.D(D), .W(W), .CW(CW)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_last    (in_last),
        .in_ready   (in_ready),
        .im_wr_en   (im_wr_en),
        .im_wr_addr (im_wr_addr),
        .im_wr_data (im_wr_data),
        .core_rst   (core_rst),
        .core_done  (core_done),
        .busy       (busy),
        .finished   (finished),
        .err_ovf    (err_ovf),
        .prog_len   (prog_len),
        .run_cycles (run_cycles)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_write(input string tag, input int addr, input int data, input int len);
        chk({tag, " en"}, 32'(im_wr_en), 32'd1);
        chk({tag, " addr"}, 32'(im_wr_addr), 32'(addr));
        chk({tag, " data"}, 32'(im_wr_data), 32'(data));
        chk({tag, " len"}, 32'(prog_len), 32'(len));
    endtask

    initial begin
        reset = 1'b0; in_data = '0; in_valid = 1'b0; in_last = 1'b0; core_done = 1'b0;
        #12;
        chk("rst core_rst", 32'(core_rst), 32'd1);
        chk("rst busy", 32'(busy), 32'd1);
        chk("rst in_ready", 32'(in_ready), 32'd1);
        chk("rst im_wr_en", 32'(im_wr_en), 32'd0);
        chk("rst im_wr_addr", 32'(im_wr_addr), 32'd0);
        chk("rst im_wr_data", 32'(im_wr_data), 32'd0);
        chk("rst finished", 32'(finished), 32'd0);
        chk("rst err_ovf", 32'(err_ovf), 32'd0);
        chk("rst prog_len", 32'(prog_len), 32'd0);
        chk("rst run_cycles", 32'(run_cycles), 32'd0);
        reset = 1'b1;
        tick();

        // Three-word program, valid held
        in_valid = 1'b1; in_data = 9'h1A0; in_last = 1'b0;
        tick(); chk_write("w0", 0, 'h1A0, 1);
        in_data = 9'h0F3;
        tick(); chk_write("w1", 1, 'h0F3, 2);
        in_data = 9'h1FF; in_last = 1'b1;
        tick(); chk_write("w2", 2, 'h1FF, 3);
        in_valid = 1'b0; in_last = 1'b0;
        chk("start core_rst", 32'(core_rst), 32'd1);
        chk("start in_ready", 32'(in_ready), 32'd0);
        chk("start busy", 32'(busy), 32'd1);
        tick();
        chk("run core_rst", 32'(core_rst), 32'd0);
        chk("run im_wr_en", 32'(im_wr_en), 32'd0);

        // in_valid during RUN is ignored
        in_valid = 1'b1; in_data = 9'h055;
        chk("run in_ready", 32'(in_ready), 32'd0);
        tick();
        chk("run no write", 32'(im_wr_en), 32'd0);
        chk("run prog_len", 32'(prog_len), 32'd3);
        in_valid = 1'b0;
        repeat (9) tick();
        chk("run still", 32'(busy), 32'd1);
        core_done = 1'b1;
        tick();
        core_done = 1'b0;
        chk("done finished", 32'(finished), 32'd1);
        chk("done core_rst", 32'(core_rst), 32'd1);
        chk("done busy", 32'(busy), 32'd0);
        chk("done in_ready", 32'(in_ready), 32'd1);
        chk("done run_cycles", 32'(run_cycles), 32'(RUN11));
        tick();
        chk("done hold cycles", 32'(run_cycles), 32'(RUN11));

        // Gapped load from DONE, plus core_done pulse while loading
        in_valid = 1'b1; in_data = 9'h011;
        tick(); chk_write("g0", 0, 'h011, 1);
        chk("g0 finished", 32'(finished), 32'd0);
        chk("g0 busy", 32'(busy), 32'd1);
        in_valid = 1'b0; core_done = 1'b1;
        tick();
        chk("gap en", 32'(im_wr_en), 32'd0);
        chk("load done finished", 32'(finished), 32'd0);
        chk("load done ready", 32'(in_ready), 32'd1);
        core_done = 1'b0;
        in_valid = 1'b1; in_data = 9'h022;
        tick(); chk_write("g1", 1, 'h022, 2);
        in_valid = 1'b0;
        tick(); tick();
        chk("gap2 en", 32'(im_wr_en), 32'd0);
        chk("gap2 len", 32'(prog_len), 32'd2);
        in_valid = 1'b1; in_data = 9'h033; in_last = 1'b1;
        tick(); chk_write("g2", 2, 'h033, 3);
        in_valid = 1'b0; in_last = 1'b0;
        chk("g start cycles", 32'(run_cycles), 32'd0);
        tick();
        chk("g run core_rst", 32'(core_rst), 32'd0);
        tick();

        // Asynchronous reset mid-RUN
        #2 reset = 1'b0;
        #1;
        chk("arst core_rst", 32'(core_rst), 32'd1);
        chk("arst in_ready", 32'(in_ready), 32'd1);
        chk("arst prog_len", 32'(prog_len), 32'd0);
        chk("arst finished", 32'(finished), 32'd0);
        chk("arst run_cycles", 32'(run_cycles), 32'd0);
        #3 reset = 1'b1;
        tick();

        // Overflow: 17 words, no last
        in_valid = 1'b1;
        for (int i = 0; i < 16; i++) begin
            in_data = 9'(i * 3 + 7);
            tick();
            chk("ovf addr", 32'(im_wr_addr), 32'(i));
            chk("ovf en", 32'(im_wr_en), 32'd1);
        end
        chk("ovf err", 32'(err_ovf), 32'd1);
        chk("ovf ready", 32'(in_ready), 32'd0);
        chk("ovf len", 32'(prog_len), 32'd16);
        chk("ovf busy", 32'(busy), 32'd0);
        in_data = 9'h1EE;
        tick();
        chk("ovf 17th en", 32'(im_wr_en), 32'd0);
        core_done = 1'b1; in_last = 1'b1;
        tick(); tick();
        chk("ovf sticky err", 32'(err_ovf), 32'd1);
        chk("ovf sticky rdy", 32'(in_ready), 32'd0);
        chk("ovf core_rst", 32'(core_rst), 32'd1);
        in_valid = 1'b0; in_last = 1'b0; core_done = 1'b0;
        #2 reset = 1'b0;
        #3 reset = 1'b1;
        tick();
        chk("post rst err", 32'(err_ovf), 32'd0);

        // 16 words, last on 16th -> START
        in_valid = 1'b1;
        for (int i = 0; i < 16; i++) begin
            in_data = 9'(200 + i);
            in_last = (i == 15);
            tick();
            chk("full addr", 32'(im_wr_addr), 32'(i));
        end
        in_valid = 1'b0; in_last = 1'b0;
        chk("full err", 32'(err_ovf), 32'd0);
        chk("full len", 32'(prog_len), 32'd16);
        chk("full start rdy", 32'(in_ready), 32'd0);
        chk("full start rst", 32'(core_rst), 32'd1);
        tick();
        chk("full run", 32'(core_rst), 32'd0);
        core_done = 1'b1;
        tick();
        core_done = 1'b0;
        chk("full done", 32'(finished), 32'd1);
        chk("full cycles", 32'(run_cycles), 32'(RUN1));

        // Single-word reload from DONE
        in_valid = 1'b1; in_last = 1'b1; in_data = 9'h0AB;
        tick(); chk_write("reload", 0, 'h0AB, 1);
        in_valid = 1'b0; in_last = 1'b0;
        chk("reload finished", 32'(finished), 32'd0);
        chk("reload start rst", 32'(core_rst), 32'd1);
        chk("reload ready", 32'(in_ready), 32'd0);
        chk("reload cycles", 32'(run_cycles), 32'd0);
        tick();
        chk("reload run", 32'(core_rst), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
